// File: rtl/card_pkg.sv
// Shared types and helpers for the card dealer: card codes, FSM states, baccarat value.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package card_pkg;

    typedef logic [3:0] card_t;

    localparam card_t CARD_NONE = 4'd0;
    localparam card_t CARD_ACE  = 4'd1;
    localparam card_t CARD_KING = 4'd13;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ARMED    = 2'd1,
        DEAL     = 2'd2,
        WAIT_REL = 2'd3
    } dealer_state_t;

    // Baccarat value of a card: pip cards count face value, 10 and court cards count zero.
    function automatic logic [3:0] card_value(input card_t c);
        if (c >= CARD_ACE && c <= 4'd9) begin
            return c;
        end
        return 4'd0;
    endfunction

endpackage

// File: rtl/card_dealer_if.sv
// Button/clear inputs and card/hand outputs exchanged between the dealer and its user.
// Latency: none (wires only).
// Backpressure: none; card_valid is a fire-and-forget strobe.
interface card_dealer_if;
    import card_pkg::*;

    logic       deal_btn;
    logic       clear_hand;
    card_t      card;
    logic       card_valid;
    logic [1:0] dealt_count;
    logic       hand_full;
    logic [3:0] score;

    modport master (
        input  deal_btn, clear_hand,
        output card, card_valid, dealt_count, hand_full, score
    );

    modport slave (
        output deal_btn, clear_hand,
        input  card, card_valid, dealt_count, hand_full, score
    );

endinterface

// File: rtl/btn_debounce.sv
// Synchronises a raw pushbutton and emits a one-cycle press pulse after a stable hold.
// Latency: press is high in the cycle after edge DEBOUNCE_CYCLES+3 of the button being high.
// Backpressure: none; a held button yields one pulse, a low cycle while arming restarts debounce.
module btn_debounce
    import card_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic press
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] DLAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          btn_s;
    logic [CW-1:0] dcnt;
    dealer_state_t state;
    dealer_state_t state_nx;

    // Two-flop synchroniser; only btn_s is used downstream.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            btn_s <= 1'b0;
        end else begin
            sync1 <= btn_raw;
            btn_s <= sync1;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic: arm on high, abort on any low while arming, wait for release after a deal.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:     if (btn_s) state_nx = ARMED;
            ARMED: begin
                if (!btn_s) begin
                    state_nx = IDLE;
                end else if (dcnt == DLAST) begin
                    state_nx = DEAL;
                end
            end
            DEAL:     state_nx = WAIT_REL;
            WAIT_REL: if (!btn_s) state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    // Output logic: the press pulse is exactly the single DEAL cycle.
    always_comb begin
        press = 1'b0;
        if (state == DEAL) begin
            press = 1'b1;
        end
    end

    // Debounce counter: cleared while idle, counts consecutive high cycles while armed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dcnt <= '0;
        end else if (state == IDLE) begin
            dcnt <= '0;
        end else if (state == ARMED && btn_s && dcnt != DLAST) begin
            dcnt <= dcnt + CW'(1);
        end
    end

endmodule

// File: rtl/card_dealer.sv
// Deals cards 1..13 from a free-running counter on debounced presses and keeps a baccarat hand.
// Latency: button high at edge 1 -> card/card_valid update at edge DEBOUNCE_CYCLES+4.
// Backpressure: none; presses with a full hand are ignored, clear_hand overrides a same-cycle deal.
module card_dealer
    import card_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int MAX_CARDS       = 3
) (
    input  logic          clk,
    input  logic          reset,
    card_dealer_if.master bus
);

    localparam logic [1:0] MAX_CNT = 2'(MAX_CARDS);

    card_t      rng;
    card_t      card_q;
    logic [1:0] count_q;
    logic [3:0] score_q;
    logic       valid_q;
    logic       press;
    logic       full;
    logic [4:0] sum;
    logic [3:0] score_nx;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
        .clk     (clk),
        .reset   (reset),
        .btn_raw (bus.deal_btn),
        .press   (press)
    );

    // Free-running card source cycling 1..13; never holds 0, 14 or 15.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rng <= CARD_ACE;
        end else if (rng == CARD_KING) begin
            rng <= CARD_ACE;
        end else begin
            rng <= rng + 4'd1;
        end
    end

    assign full = (count_q == MAX_CNT);

    // Next score: both operands are below 10, so one conditional subtract gives mod 10.
    always_comb begin
        sum      = {1'b0, score_q} + {1'b0, card_value(rng)};
        score_nx = sum[3:0];
        if (sum >= 5'd10) begin
            score_nx = 4'(sum - 5'd10);
        end
    end

    // Hand registers: clear wins over a deal; a full hand drops the press silently.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            card_q  <= CARD_NONE;
            count_q <= 2'd0;
            score_q <= 4'd0;
            valid_q <= 1'b0;
        end else if (bus.clear_hand) begin
            card_q  <= CARD_NONE;
            count_q <= 2'd0;
            score_q <= 4'd0;
            valid_q <= 1'b0;
        end else if (press && !full) begin
            card_q  <= rng;
            count_q <= count_q + 2'd1;
            score_q <= score_nx;
            valid_q <= 1'b1;
        end else begin
            valid_q <= 1'b0;
        end
    end

    assign bus.card        = card_q;
    assign bus.card_valid  = valid_q;
    assign bus.dealt_count = count_q;
    assign bus.hand_full   = full;
    assign bus.score       = score_q;

endmodule
